// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// state codes, datapath select encodings and the DECODE dispatch helper.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_NOP   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MADDR  = 4'd2;
   localparam logic [3:0] S_MRD    = 4'd3;
   localparam logic [3:0] S_MWB    = 4'd4;
   localparam logic [3:0] S_MWR    = 4'd5;
   localparam logic [3:0] S_REXE   = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BR     = 4'd8;
   localparam logic [3:0] S_JMP    = 4'd9;
   localparam logic [3:0] S_JAL    = 4'd10;
   localparam logic [3:0] S_JR     = 4'd11;
   localparam logic [3:0] S_IEXE   = 4'd12;
   localparam logic [3:0] S_IWB    = 4'd13;
   localparam logic [3:0] S_TRAP   = 4'd14;

   localparam logic [2:0] AOP_ADD  = 3'd0;
   localparam logic [2:0] AOP_SUB  = 3'd1;
   localparam logic [2:0] AOP_FUNC = 3'd2;
   localparam logic [2:0] AOP_AND  = 3'd3;
   localparam logic [2:0] AOP_OR   = 3'd4;
   localparam logic [2:0] AOP_SLT  = 3'd5;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_A      = 2'b11;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_PC  = 2'b10;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] CAUSE_ILL = 2'b01;
   localparam logic [1:0] CAUSE_TMO = 2'b10;

   function automatic logic [3:0] decode_next(input logic [5:0] op, input logic [5:0] func);
      logic [3:0] nxt;
      case (op)
         OP_LW, OP_SW:                        nxt = S_MADDR;
         OP_RTYPE:
            if (func == FN_JR)                nxt = S_JR;
            else if (func == FN_NOP)          nxt = S_FETCH;
            else                              nxt = S_REXE;
         OP_BEQ, OP_BNE:                      nxt = S_BR;
         OP_J:                                nxt = S_JMP;
         OP_JAL:                              nxt = S_JAL;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   nxt = S_IEXE;
         default:                             nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait counter: counts idle cycles of a memory state and flags
// completion or timeout. MEM_HS=0 treats memory as single-cycle.
module mc_mem_wait #(
   parameter int MEM_HS      = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic mem_ready,
   output logic done,
   output logic timeout
);

   localparam logic [15:0] TO_VAL = 16'(TIMEOUT_CYC);

   logic [15:0] cnt_q, cnt_d;

   // Outside a memory state, or on completion, the count returns to zero,
   // so every memory state is entered with a cleared counter.
   always_comb begin
      cnt_d = '0;
      if (active && (MEM_HS != 0) && !mem_ready)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done    = active && ((MEM_HS == 0) || mem_ready);
   assign timeout = active && (MEM_HS != 0) && (TIMEOUT_CYC != 0) &&
                    !mem_ready && (cnt_q == TO_VAL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory handshake/timeout and trap.
// Optional perf counters (cyc_cnt, ret_cnt) when MC_CTRL_PERF_EN is defined.
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int ALUOP_W     = 3,
   parameter int MEM_HS      = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic [5:0]         func,
   input  logic               mem_ready,
   output logic               pc_wr,
   output logic               pc_wr_cond,
   output logic               br_ne,
   output logic               iord,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               ir_wr,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         reg_dst,
   output logic               reg_wr,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         pc_src,
   output logic               zext_imm,
   output logic               trap,
   output logic [1:0]         trap_cause
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0]        cyc_cnt,
   output logic [31:0]        ret_cnt
`endif
);

   logic [3:0] state_q, state_d;
   logic [1:0] cause_q, cause_d;
   logic       mem_active, mem_done, mem_tmo;
   logic [2:0] aop;

   assign mem_active = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);

   mc_mem_wait #(.MEM_HS(MEM_HS), .TIMEOUT_CYC(TIMEOUT_CYC)) u_wait (
      .clk       (clk),
      .rst_n     (rst_n),
      .active    (mem_active),
      .mem_ready (mem_ready),
      .done      (mem_done),
      .timeout   (mem_tmo)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH:  if (mem_done) state_d = S_DECODE;
         S_DECODE: begin
            state_d = decode_next(op, func);
            if (state_d == S_TRAP) cause_d = CAUSE_ILL;
         end
         S_MADDR:  state_d = (op == OP_SW) ? S_MWR : S_MRD;
         S_MRD:    if (mem_done) state_d = S_MWB;
         S_MWR:    if (mem_done) state_d = S_FETCH;
         S_REXE:   state_d = S_RWB;
         S_IEXE:   state_d = S_IWB;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
      // timeout only fires with mem_ready low, so it never races a completion
      if (mem_tmo) begin
         state_d = S_TRAP;
         cause_d = CAUSE_TMO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // Outputs are held at zero combinationally for as long as reset is low.
   always_comb begin
      pc_wr      = 1'b0;
      pc_wr_cond = 1'b0;
      br_ne      = 1'b0;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      mem_to_reg = M2R_ALU;
      reg_dst    = RD_RT;
      reg_wr     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      aop        = AOP_ADD;
      pc_src     = PCS_ALU;
      zext_imm   = 1'b0;
      trap       = 1'b0;
      trap_cause = '0;
      if (rst_n) begin
         trap_cause = cause_q;
         case (state_q)
            S_FETCH: begin
               mem_rd    = 1'b1;
               alu_src_b = 2'b01;
               ir_wr     = mem_done;
               pc_wr     = mem_done;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MRD: begin
               mem_rd = 1'b1;
               iord   = 1'b1;
            end
            S_MWB: begin
               reg_wr     = 1'b1;
               mem_to_reg = M2R_MDR;
            end
            S_MWR: begin
               mem_wr = 1'b1;
               iord   = 1'b1;
            end
            S_REXE: begin
               alu_src_a = 1'b1;
               aop       = AOP_FUNC;
            end
            S_RWB: begin
               reg_wr  = 1'b1;
               reg_dst = RD_RD;
            end
            S_BR: begin
               alu_src_a  = 1'b1;
               aop        = AOP_SUB;
               pc_wr_cond = 1'b1;
               pc_src     = PCS_ALUOUT;
               br_ne      = (op == OP_BNE);
            end
            S_JMP: begin
               pc_wr  = 1'b1;
               pc_src = PCS_JUMP;
            end
            S_JAL: begin
               pc_wr      = 1'b1;
               pc_src     = PCS_JUMP;
               reg_wr     = 1'b1;
               reg_dst    = RD_RA;
               mem_to_reg = M2R_PC;
            end
            S_JR: begin
               pc_wr  = 1'b1;
               pc_src = PCS_A;
            end
            S_IEXE: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               case (op)
                  OP_ANDI: begin aop = AOP_AND; zext_imm = 1'b1; end
                  OP_ORI:  begin aop = AOP_OR;  zext_imm = 1'b1; end
                  OP_SLTI: aop = AOP_SLT;
                  default: aop = AOP_ADD;
               endcase
            end
            S_IWB:  reg_wr = 1'b1;
            S_TRAP: trap   = 1'b1;
            default: ;
         endcase
      end
   end

   assign alu_op = ALUOP_W'(aop);

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

   // nop DECODE->FETCH is also a non-FETCH to FETCH transition
   always_comb begin
      cyc_d = (state_q != S_TRAP) ? cyc_q + 32'd1 : cyc_q;
      ret_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ? ret_q + 32'd1 : ret_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end

   assign cyc_cnt = cyc_q;
   assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: an instruction-level model expands each
// instruction into its step list and queues the expected per-cycle outputs.
module tb_mc_ctrl_fsm;

   localparam int AW = 4;
   localparam int TO = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [5:0]     op = '0, func = '0;
   logic           mem_ready = 1'b0;
   logic           pc_wr, pc_wr_cond, br_ne, iord, mem_rd, mem_wr, ir_wr;
   logic [1:0]     mem_to_reg, reg_dst;
   logic           reg_wr, alu_src_a;
   logic [1:0]     alu_src_b;
   logic [AW-1:0]  alu_op;
   logic [1:0]     pc_src;
   logic           zext_imm, trap;
   logic [1:0]     trap_cause;

   mc_ctrl_fsm #(.ALUOP_W(AW), .MEM_HS(1), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func(func), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .br_ne(br_ne), .iord(iord),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr), .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst), .reg_wr(reg_wr), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .zext_imm(zext_imm), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic pc_wr, pc_wr_cond, br_ne, iord, mem_rd, mem_wr, ir_wr;
      logic [1:0] mem_to_reg, reg_dst;
      logic reg_wr, alu_src_a;
      logic [1:0] alu_src_b;
      logic [AW-1:0] alu_op;
      logic [1:0] pc_src;
      logic zext_imm, trap;
      logic [1:0] trap_cause;
   } ov_t;

   typedef enum int {P_FETCH, P_DEC, P_MADDR, P_MRD, P_MWB, P_MWR, P_REXE, P_RWB,
                     P_BR, P_JMP, P_JAL, P_JR, P_IEXE, P_IWB, P_TRAP} ph_t;

   ov_t   got;
   ov_t   exp_q[$];
   string tag_q[$];
   int    errs = 0, checks = 0;

   ph_t        ph_q[$];
   int         m_wait = 0;
   bit         m_trap = 0;
   logic [1:0] m_cause = '0;
   logic [5:0] m_op = '0, m_func = '0;
   int         rdy_mode = 1;
   bit         rdy_q[$];

   assign got = {pc_wr, pc_wr_cond, br_ne, iord, mem_rd, mem_wr, ir_wr, mem_to_reg,
                 reg_dst, reg_wr, alu_src_a, alu_src_b, alu_op, pc_src, zext_imm,
                 trap, trap_cause};

   task automatic chk(input bit ok, input string msg);
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL %s @%0t: got %h", msg, $time, got);
      end
   endtask

   function automatic void plan(input logic [5:0] o, input logic [5:0] f);
      ph_q.delete();
      ph_q.push_back(P_FETCH);
      ph_q.push_back(P_DEC);
      case (o)
         6'h23: begin ph_q.push_back(P_MADDR); ph_q.push_back(P_MRD); ph_q.push_back(P_MWB); end
         6'h2B: begin ph_q.push_back(P_MADDR); ph_q.push_back(P_MWR); end
         6'h00: if (f == 6'h08) ph_q.push_back(P_JR);
                else if (f != 6'h00) begin ph_q.push_back(P_REXE); ph_q.push_back(P_RWB); end
         6'h04, 6'h05: ph_q.push_back(P_BR);
         6'h02: ph_q.push_back(P_JMP);
         6'h03: ph_q.push_back(P_JAL);
         6'h08, 6'h0C, 6'h0D, 6'h0A: begin ph_q.push_back(P_IEXE); ph_q.push_back(P_IWB); end
         default: ph_q.push_back(P_TRAP);
      endcase
   endfunction

   function automatic ov_t step(input logic mr);
      ov_t e = '0;
      ph_t p;
      if (!m_trap && ph_q[0] == P_TRAP) begin m_trap = 1; m_cause = 2'b01; end
      if (m_trap) begin
         e.trap = 1'b1;
         e.trap_cause = m_cause;
         return e;
      end
      p = ph_q[0];
      case (p)
         P_FETCH: begin e.mem_rd = 1; e.alu_src_b = 2'b01; e.ir_wr = mr; e.pc_wr = mr; end
         P_DEC:   e.alu_src_b = 2'b11;
         P_MADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         P_MRD:   begin e.mem_rd = 1; e.iord = 1; end
         P_MWB:   begin e.reg_wr = 1; e.mem_to_reg = 2'b01; end
         P_MWR:   begin e.mem_wr = 1; e.iord = 1; end
         P_REXE:  begin e.alu_src_a = 1; e.alu_op = AW'(2); end
         P_RWB:   begin e.reg_wr = 1; e.reg_dst = 2'b01; end
         P_BR:    begin e.alu_src_a = 1; e.alu_op = AW'(1); e.pc_wr_cond = 1;
                        e.pc_src = 2'b01; e.br_ne = (m_op == 6'h05); end
         P_JMP:   begin e.pc_wr = 1; e.pc_src = 2'b10; end
         P_JAL:   begin e.pc_wr = 1; e.pc_src = 2'b10; e.reg_wr = 1;
                        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
         P_JR:    begin e.pc_wr = 1; e.pc_src = 2'b11; end
         P_IEXE:  begin
            e.alu_src_a = 1; e.alu_src_b = 2'b10;
            e.alu_op   = (m_op == 6'h0C) ? AW'(3) : (m_op == 6'h0D) ? AW'(4) :
                         (m_op == 6'h0A) ? AW'(5) : AW'(0);
            e.zext_imm = (m_op == 6'h0C) || (m_op == 6'h0D);
         end
         P_IWB:   e.reg_wr = 1;
         default: ;
      endcase
      if (p == P_FETCH || p == P_MRD || p == P_MWR) begin
         if (mr) begin void'(ph_q.pop_front()); m_wait = 0; end
         else if (m_wait == TO) begin m_trap = 1; m_cause = 2'b10; end
         else m_wait++;
      end else begin
         void'(ph_q.pop_front());
      end
      return e;
   endfunction

   function automatic bit next_mr();
      if (rdy_q.size() > 0) return rdy_q.pop_front();
      if (rdy_mode == 1) return 1'b1;
      if (rdy_mode == 2) return 1'b0;
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic cyc(input logic rn);
      logic  mr;
      string t;
      ov_t   e;
      @(posedge clk); #1;
      mr = next_mr();
      rst_n = rn; mem_ready = mr; op = m_op; func = m_func;
      if (!rn) begin
         e = '0; t = "reset";
         ph_q.delete(); m_trap = 0; m_cause = '0; m_wait = 0;
      end else begin
         t = m_trap ? "trap" : ph_q[0].name();
         e = step(mr);
      end
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   // One instruction; rst_at >= 0 pulses reset in that cycle of the instruction.
   task automatic run(input logic [5:0] o, input logic [5:0] f, input int rst_at);
      int n = 0;
      m_op = o; m_func = f; m_wait = 0;
      plan(o, f);
      while (ph_q.size() > 0 && !m_trap) begin
         if (n == rst_at) begin cyc(1'b0); return; end
         cyc(1'b1);
         n++;
      end
      if (m_trap) begin
         repeat (3) cyc(1'b1);
         #1;
         chk(trap === 1'b1 && trap_cause === m_cause, "trap-hold");
         cyc(1'b0);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ov_t   e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (got !== e) begin
            errs++;
            $display("FAIL %s @%0t: got %h expected %h", t, $time, got, e);
         end
      end
   end

   logic [5:0] ops [11] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02,
                            6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A};

   initial begin
      rdy_mode = 1;
      cyc(1'b0); cyc(1'b0);
      #1;
      chk(got === '0, "reset-state");
      // every opcode with memory tied ready
      run(6'h23, 6'h00, -1);
      run(6'h2B, 6'h00, -1);
      run(6'h00, 6'h20, -1);
      run(6'h08, 6'h00, -1);
      run(6'h0C, 6'h00, -1);
      run(6'h0D, 6'h00, -1);
      run(6'h0A, 6'h00, -1);
      run(6'h04, 6'h00, -1);
      run(6'h05, 6'h00, -1);
      run(6'h02, 6'h00, -1);
      run(6'h03, 6'h00, -1);
      run(6'h00, 6'h08, -1);
      run(6'h00, 6'h00, -1);
      // slow fetch: three idle cycles, then ready
      rdy_q = '{0, 0, 0};
      run(6'h23, 6'h00, -1);
      // sw store never accepted -> timeout trap, then reset
      rdy_q = '{1};
      rdy_mode = 2;
      run(6'h2B, 6'h00, -1);
      rdy_mode = 1;
      run(6'h3F, 6'h00, -1);
      run(6'h00, 6'h22, 2);
      run(6'h00, 6'h25, -1);
      rdy_mode = 0;
      for (int i = 0; i < 400; i++) begin
         logic [5:0] o, f;
         int ra;
         o  = ($urandom_range(0, 11) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
         case ($urandom_range(0, 3))
            0:       f = 6'h00;
            1:       f = 6'h08;
            default: f = 6'($urandom);
         endcase
         ra = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : -1;
         run(o, f, ra);
      end
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
